// File: rtl/tpu_pkg.sv
// Shared TPU definitions: command opcodes, controller state encoding,
// default parameter values and a counter-width helper.
package tpu_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_FIFO_INPUTS = 4;
    localparam int DEFAULT_FIFO_DEPTH  = 4;
    localparam int DEFAULT_ADDR_WIDTH  = 8;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_DRAIN = 1'b1
    } cmdOpT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrlStateT;

    // One counter serves both LOAD (depth+1 cycles) and DRAIN
    // (depth+inputs-1 cycles); this width holds the longest without wrapping.
    function automatic int counterWidth(input int depth, input int inputs);
        return $clog2(depth + inputs);
    endfunction

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Command, weight-memory and weight-FIFO signals of the weight load controller.
interface weight_load_ctrl_if #(
    parameter int DATA_WIDTH  = tpu_pkg::DEFAULT_DATA_WIDTH,
    parameter int FIFO_INPUTS = tpu_pkg::DEFAULT_FIFO_INPUTS,
    parameter int ADDR_WIDTH  = tpu_pkg::DEFAULT_ADDR_WIDTH
);
    logic                              cmdValid;
    logic                              cmdReady;
    logic                              cmdOp;
    logic [ADDR_WIDTH-1:0]             cmdAddr;
    logic                              memRdEn;
    logic [ADDR_WIDTH-1:0]             memAddr;
    logic [DATA_WIDTH*FIFO_INPUTS-1:0] memData;
    logic [FIFO_INPUTS-1:0]            fifoEn;
    logic [DATA_WIDTH*FIFO_INPUTS-1:0] fifoWeightIn;
    logic                              busy;
    logic                              done;

    // Requester side: issues commands and returns memory data.
    modport master (
        output cmdValid, cmdOp, cmdAddr, memData,
        input  cmdReady, memRdEn, memAddr, fifoEn, fifoWeightIn, busy, done
    );

    // Controller side.
    modport slave (
        input  cmdValid, cmdOp, cmdAddr, memData,
        output cmdReady, memRdEn, memAddr, fifoEn, fifoWeightIn, busy, done
    );
endinterface

// File: rtl/weight_load_ctrl_skew_en_gen.sv
// Diagonal shift-enable pattern for draining the weight FIFOs: column c
// shifts during cycles c .. c+FIFO_DEPTH-1, so columns empty in a skew.
module skew_en_gen #(
    parameter int FIFO_INPUTS = tpu_pkg::DEFAULT_FIFO_INPUTS,
    parameter int FIFO_DEPTH  = tpu_pkg::DEFAULT_FIFO_DEPTH,
    parameter int CNT_WIDTH   = 3
) (
    input  logic [CNT_WIDTH-1:0]   count,
    input  logic                   active,
    output logic [FIFO_INPUTS-1:0] en
);
    for (genvar gi = 0; gi < FIFO_INPUTS; gi++) begin : g_col
        // Window of FIFO_DEPTH cycles starting gi cycles after drain start.
        assign en[gi] = active && (int'(count) >= gi) && (int'(count) < gi + FIFO_DEPTH);
    end
endmodule

// File: rtl/weight_load_ctrl.sv
// Weight load controller: LOAD streams FIFO_DEPTH memory rows into the
// weight FIFOs, DRAIN shifts the FIFOs out along a diagonal.
module weight_load_ctrl
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int FIFO_INPUTS = DEFAULT_FIFO_INPUTS,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
) (
    input logic               clk,
    input logic               reset,
    weight_load_ctrl_if.slave bus
);
    localparam int CNT_WIDTH = counterWidth(FIFO_DEPTH, FIFO_INPUTS);
    localparam logic [CNT_WIDTH-1:0] LOAD_LAST      = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] LOAD_LAST_READ = CNT_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST     = CNT_WIDTH'(FIFO_DEPTH + FIFO_INPUTS - 2);

    ctrlStateT                         stateReg, stateNext;
    logic [CNT_WIDTH-1:0]              cntReg, cntNext;
    logic                              memRdEnReg;
    logic [ADDR_WIDTH-1:0]             memAddrReg;
    logic [FIFO_INPUTS-1:0]            drainEn;
    logic [DATA_WIDTH*FIFO_INPUTS-1:0] rowData;
    logic                              accept;

    assign accept  = (stateReg == ST_IDLE) && bus.cmdValid;
    assign rowData = bus.memData;

    skew_en_gen #(
        .FIFO_INPUTS(FIFO_INPUTS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_skew (
        .count (cntReg),
        .active(stateReg == ST_DRAIN),
        .en    (drainEn)
    );

    // State and cycle counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= ST_IDLE;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    // Next state; counter restarts at 0 on every state entry.
    always_comb begin
        stateNext = stateReg;
        cntNext   = '0;
        case (stateReg)
            ST_IDLE: begin
                if (bus.cmdValid)
                    stateNext = (cmdOpT'(bus.cmdOp) == OP_DRAIN) ? ST_DRAIN : ST_LOAD;
            end
            ST_LOAD: begin
                if (cntReg == LOAD_LAST) stateNext = ST_DONE;
                else                     cntNext   = cntReg + CNT_WIDTH'(1);
            end
            ST_DRAIN: begin
                if (cntReg == DRAIN_LAST) stateNext = ST_DONE;
                else                      cntNext   = cntReg + CNT_WIDTH'(1);
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Registered memory read port: the address register doubles as the
    // latched base address and steps once per LOAD read cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memRdEnReg <= 1'b0;
            memAddrReg <= '0;
        end else if (accept) begin
            memRdEnReg <= (cmdOpT'(bus.cmdOp) == OP_LOAD);
            memAddrReg <= bus.cmdAddr;
        end else if (stateReg == ST_LOAD && cntReg < LOAD_LAST_READ) begin
            memRdEnReg <= 1'b1;
            memAddrReg <= memAddrReg + ADDR_WIDTH'(1);
        end else begin
            memRdEnReg <= 1'b0;
        end
    end

    assign bus.memRdEn = memRdEnReg;
    assign bus.memAddr = memAddrReg;

    // Outputs decoded from state; memory data arrives one cycle after each
    // read, so the FIFOs shift from LOAD cycle 1 onward.
    always_comb begin
        bus.cmdReady     = 1'b0;
        bus.busy         = 1'b0;
        bus.done         = 1'b0;
        bus.fifoEn       = '0;
        bus.fifoWeightIn = '0;
        case (stateReg)
            ST_IDLE: bus.cmdReady = 1'b1;
            ST_LOAD: begin
                bus.busy = 1'b1;
                if (cntReg != '0) begin
                    bus.fifoEn       = '1;
                    bus.fifoWeightIn = rowData;
                end
            end
            ST_DRAIN: begin
                bus.busy   = 1'b1;
                bus.fifoEn = drainEn;
            end
            default: bus.done = 1'b1;
        endcase
    end

endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per weight.
REQ-002 SHALL have parameter FIFO_INPUTS, default 4, number of weight FIFO columns.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of weight FIFO stages.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, weight memory address width.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port cmdValid  input  1  command request.
REQ-008 SHALL have port cmdReady  output  1  command accepted when cmdValid && cmdReady.
REQ-009 SHALL have port cmdOp  input  1  0 = LOAD, 1 = DRAIN.
REQ-010 SHALL have port cmdAddr  input  ADDR_WIDTH  base row address (LOAD only).
REQ-011 SHALL have port memRdEn  output  1  weight memory read strobe.
REQ-012 SHALL have port memAddr  output  ADDR_WIDTH  weight memory row address.
REQ-013 SHALL have port memData  input  DATA_WIDTH*FIFO_INPUTS  row data, valid one cycle after memRdEn.
REQ-014 SHALL have port fifoEn  output  FIFO_INPUTS  per-column FIFO shift enable, bit 0 = leftmost column.
REQ-015 SHALL have port fifoWeightIn  output  DATA_WIDTH*FIFO_INPUTS  FIFO input row, LSB slice = leftmost column.
REQ-016 SHALL have port busy  output  1  high in LOAD or DRAIN.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, LOAD, DRAIN, DONE; cmdReady = 1 only in IDLE.
REQ-019 SHALL, on accept, latch cmdAddr and go to LOAD (cmdOp=0) or DRAIN (cmdOp=1) at the next edge.
REQ-020 SHALL, in LOAD cycle k (k = 0..FIFO_DEPTH-1), drive registered memRdEn=1, memAddr=(latched addr + k) mod 2^ADDR_WIDTH.
REQ-021 SHALL, in LOAD cycle k+1 (k = 0..FIFO_DEPTH-1), drive fifoEn all-ones and fifoWeightIn = memData (combinational pass-through).
REQ-022 SHALL exit LOAD after cycle FIFO_DEPTH (FIFO_DEPTH+1 cycles total), so row cmdAddr ends in the deepest FIFO stage.
REQ-023 SHALL, in DRAIN cycle t (t = 0..FIFO_DEPTH+FIFO_INPUTS-2), drive fifoEn[c]=1 iff c <= t < c+FIFO_DEPTH; fifoWeightIn = 0; memRdEn = 0.
REQ-024 SHALL spend exactly one cycle in DONE with done=1, busy=0, cmdReady=0, then return to IDLE.
REQ-025 SHALL drive fifoEn=0, fifoWeightIn=0, memRdEn=0 whenever not explicitly required otherwise (IDLE, DONE, LOAD cycle 0 for fifoEn).
REQ-026 SHALL ignore cmdValid outside IDLE; a held request is accepted on the first IDLE cycle.
REQ-027 SHALL use a single cycle counter of width clog2(FIFO_DEPTH+FIFO_INPUTS) that never wraps within a command.

Reset
REQ-028 SHALL, on reset assertion at any time (including mid-LOAD/DRAIN), immediately force IDLE, counter 0, memRdEn=0, memAddr=0, fifoEn=0, fifoWeightIn=0, busy=0, done=0, cmdReady=1.
REQ-029 SHALL not emit done for a command aborted by reset.

Structure
REQ-030 SHALL place cmdOp encodings, state encoding and default parameter values in the shared tpu package.
REQ-031 SHALL implement the DRAIN diagonal enable as sub-module skew_en_gen (inputs: count, active; output: FIFO_INPUTS enables).

Verification
REQ-032 Reset: assert reset during LOAD cycle 2 -> all outputs 0 same cycle, cmdReady=1 after release, no done pulse.
REQ-033 LOAD cmdAddr=0x10, memory row k = {4{k+1}} -> memAddr 0x10..0x13 in cycles 0-3; fifoEn=4'hF with fifoWeightIn 0x01010101..0x04040404 in cycles 1-4; done in cycle 5.
REQ-034 LOAD cmdAddr=0xFE -> memAddr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-035 DRAIN -> fifoEn 0001, 0011, 0111, 1111, 1110, 1100, 1000 over cycles 0-6; done in cycle 7; memRdEn stays 0.
REQ-036 cmdValid held high with LOAD then DRAIN queued -> second command accepted only in first IDLE cycle after done; cmdReady=0 throughout LOAD and DONE.
